sim_axi_slave: RTL and testbench

- Parametrised, synthesizable-for-simulation AXI4 slave model that stands in for a host/PCIe memory target in testbenches.
- Write path:
  - Accepts write bursts and returns an ID-tagged B response per burst.
  - Responses are in order.
- Read path:
  - Queues read requests and returns ID-tagged bursts after a programmable latency.
  - Data is address-derived.
- Out-of-range accesses return SLVERR.
- Burst counters are exported for bench checking.

---
 rtl/sim_axi_pkg.sv | 17 +
 rtl/sim_axi_slave_if.sv | 64 ++++++
 rtl/sim_axi_fifo.sv | 54 +++++
 rtl/sim_axi_slave.sv | 158 +++++++++++++++
 tb/tb_sim_axi_slave.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_axi_pkg.sv
// Shared response codes, read-FSM state type and range helper for the sim_axi_slave memory model.
package sim_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } rd_state_e;

    function automatic logic [1:0] range_resp(input logic [63:0] addr, input logic [63:0] limit);
        return (addr >= limit) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/sim_axi_slave_if.sv
// AXI4 bus bundle between a bench master and the sim_axi_slave memory model.
interface sim_axi_slave_if #(
    parameter int DW = 512,
    parameter int AW = 64,
    parameter int IW = 4
);
    logic [AW-1:0]   S_AXI_AWADDR;
    logic [IW-1:0]   S_AXI_AWID;
    logic [7:0]      S_AXI_AWLEN;
    logic [2:0]      S_AXI_AWSIZE;
    logic [1:0]      S_AXI_AWBURST;
    logic            S_AXI_AWLOCK;
    logic [3:0]      S_AXI_AWCACHE;
    logic [3:0]      S_AXI_AWQOS;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [DW-1:0]   S_AXI_WDATA;
    logic [DW/8-1:0] S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WLAST;
    logic            S_AXI_WREADY;
    logic [IW-1:0]   S_AXI_BID;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [AW-1:0]   S_AXI_ARADDR;
    logic [IW-1:0]   S_AXI_ARID;
    logic [7:0]      S_AXI_ARLEN;
    logic [2:0]      S_AXI_ARSIZE;
    logic [1:0]      S_AXI_ARBURST;
    logic            S_AXI_ARLOCK;
    logic [3:0]      S_AXI_ARCACHE;
    logic [3:0]      S_AXI_ARQOS;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [DW-1:0]   S_AXI_RDATA;
    logic [IW-1:0]   S_AXI_RID;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RLAST;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
               S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWVALID,
               S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST, S_AXI_BREADY,
               S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
               S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
               S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWVALID,
               S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_WLAST, S_AXI_BREADY,
               S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
               S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
    );
endinterface

// File: rtl/sim_axi_fifo.sv
// First-word-fall-through FIFO with registered occupancy; reset flushes contents.
import sim_axi_pkg::*;

module sim_axi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = mem_r[rd_ptr_r];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy guards every read
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= din;
    end
endmodule

// File: rtl/sim_axi_slave.sv
// AXI4 slave memory stand-in: in-order B responses, latency-delayed address-derived read bursts.
// Defining SIM_AXI_SLAVE_STALL_EN adds LFSR-driven stalls on WREADY and on new R beats.
import sim_axi_pkg::*;

module sim_axi_slave #(
    parameter int          DW         = 512,
    parameter int          AW         = 64,
    parameter int          IW         = 4,
    parameter int          AR_DEPTH   = 16,
    parameter int          WQ_DEPTH   = 16,
    parameter int          RD_LATENCY = 4,
    parameter logic [63:0] ADDR_LIMIT = 64'h1_0000_0000
) (
    input  logic           clk,
    input  logic           resetn,
    sim_axi_slave_if.slave s_axi,
    output logic [31:0]    wr_bursts,
    output logic [31:0]    rd_bursts
);
    localparam int WQ_W = AW + IW;
    localparam int BQ_W = IW + 2;
    localparam int AR_W = AW + IW + 8;

    logic            stall_s;
    logic            wq_full_s, wq_empty_s, wq_pop_s;
    logic [WQ_W-1:0] wq_dout_s;
    logic            bq_full_s, bq_empty_s, bq_pop_s;
    logic [BQ_W-1:0] bq_din_s, bq_dout_s;
    logic            arq_full_s, arq_empty_s, arq_pop_s;
    logic [AR_W-1:0] arq_dout_s;
    logic            aw_hs_s, ar_hs_s, wready_s, bvalid_s;
    logic            in_burst_s, rvalid_s, rlast_s, r_hs_s;
    rd_state_e       state_r;
    logic [AW-1:0]   addr_r;
    logic [IW-1:0]   id_r;
    logic [7:0]      len_r, beat_r, cnt_r;
    logic [1:0]      resp_r;
    logic            pend_r;
    logic [31:0]     wr_bursts_r, rd_bursts_r;
    logic            unused_ok_s;

`ifdef SIM_AXI_SLAVE_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running stall pattern generator
    always_ff @(posedge clk) begin
        if (!resetn) lfsr_r <= 16'hACE1;
        else         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
    assign stall_s = lfsr_r[0];
`else
    assign stall_s = 1'b0;
`endif

    assign aw_hs_s             = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign s_axi.S_AXI_AWREADY = resetn & ~wq_full_s;
    assign wready_s            = resetn & ~wq_empty_s & ~bq_full_s & ~stall_s;
    assign s_axi.S_AXI_WREADY  = wready_s;
    assign wq_pop_s            = s_axi.S_AXI_WVALID & wready_s & s_axi.S_AXI_WLAST;
    assign bq_din_s            = {wq_dout_s[IW-1:0], range_resp(64'(wq_dout_s[WQ_W-1:IW]), ADDR_LIMIT)};
    assign bvalid_s            = resetn & ~bq_empty_s;
    assign bq_pop_s            = bvalid_s & s_axi.S_AXI_BREADY;
    assign s_axi.S_AXI_BVALID  = bvalid_s;
    assign s_axi.S_AXI_BID     = bvalid_s ? bq_dout_s[BQ_W-1:2] : '0;
    assign s_axi.S_AXI_BRESP   = bvalid_s ? bq_dout_s[1:0] : AXI_RESP_OKAY;

    sim_axi_fifo #(.WIDTH(WQ_W), .DEPTH(WQ_DEPTH)) u_wq (
        .clk(clk), .resetn(resetn), .push(aw_hs_s),
        .din({s_axi.S_AXI_AWADDR, s_axi.S_AXI_AWID}), .pop(wq_pop_s),
        .dout(wq_dout_s), .full(wq_full_s), .empty(wq_empty_s)
    );

    sim_axi_fifo #(.WIDTH(BQ_W), .DEPTH(WQ_DEPTH)) u_bq (
        .clk(clk), .resetn(resetn), .push(wq_pop_s), .din(bq_din_s), .pop(bq_pop_s),
        .dout(bq_dout_s), .full(bq_full_s), .empty(bq_empty_s)
    );

    assign ar_hs_s             = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign s_axi.S_AXI_ARREADY = resetn & ~arq_full_s;
    assign arq_pop_s           = (state_r == IDLE) & ~arq_empty_s;

    sim_axi_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_arq (
        .clk(clk), .resetn(resetn), .push(ar_hs_s),
        .din({s_axi.S_AXI_ARADDR, s_axi.S_AXI_ARID, s_axi.S_AXI_ARLEN}), .pop(arq_pop_s),
        .dout(arq_dout_s), .full(arq_full_s), .empty(arq_empty_s)
    );

    // A beat already presented is held through any stall until it completes
    assign in_burst_s         = resetn & (state_r == BURST);
    assign rvalid_s           = in_burst_s & (pend_r | ~stall_s);
    assign rlast_s            = in_burst_s & (beat_r == len_r);
    assign r_hs_s             = rvalid_s & s_axi.S_AXI_RREADY;
    assign s_axi.S_AXI_RVALID = rvalid_s;
    assign s_axi.S_AXI_RLAST  = rlast_s;
    assign s_axi.S_AXI_RDATA  = in_burst_s ? {(DW/64){64'(addr_r)}} : '0;
    assign s_axi.S_AXI_RID    = in_burst_s ? id_r : '0;
    assign s_axi.S_AXI_RRESP  = in_burst_s ? resp_r : AXI_RESP_OKAY;

    // Read request sequencer: pop, wait out the latency, then stream beats
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            id_r        <= '0;
            len_r       <= 8'd0;
            beat_r      <= 8'd0;
            cnt_r       <= 8'd0;
            resp_r      <= AXI_RESP_OKAY;
            pend_r      <= 1'b0;
            rd_bursts_r <= 32'd0;
        end else begin
            pend_r <= rvalid_s & ~s_axi.S_AXI_RREADY;
            case (state_r)
                IDLE: begin
                    if (!arq_empty_s) begin
                        addr_r  <= arq_dout_s[AR_W-1:IW+8];
                        id_r    <= arq_dout_s[IW+7:8];
                        len_r   <= arq_dout_s[7:0];
                        beat_r  <= 8'd0;
                        resp_r  <= range_resp(64'(arq_dout_s[AR_W-1:IW+8]), ADDR_LIMIT);
                        cnt_r   <= 8'(RD_LATENCY);
                        state_r <= (RD_LATENCY == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 8'd1;
                    if (cnt_r == 8'd1) state_r <= BURST;
                end
                BURST: begin
                    if (r_hs_s) begin
                        addr_r <= addr_r + AW'(DW/8);
                        beat_r <= beat_r + 8'd1;
                        if (rlast_s) begin
                            rd_bursts_r <= rd_bursts_r + 32'd1;
                            state_r     <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Completed write-response counter
    always_ff @(posedge clk) begin
        if (!resetn)       wr_bursts_r <= 32'd0;
        else if (bq_pop_s) wr_bursts_r <= wr_bursts_r + 32'd1;
    end

    assign wr_bursts = wr_bursts_r;
    assign rd_bursts = rd_bursts_r;

    assign unused_ok_s = ^{s_axi.S_AXI_AWLEN, s_axi.S_AXI_AWSIZE, s_axi.S_AXI_AWBURST, s_axi.S_AXI_AWLOCK,
                           s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWQOS, s_axi.S_AXI_AWPROT,
                           s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB,
                           s_axi.S_AXI_ARSIZE, s_axi.S_AXI_ARBURST, s_axi.S_AXI_ARLOCK,
                           s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARQOS, s_axi.S_AXI_ARPROT};
endmodule

// File: tb/tb_sim_axi_slave.sv
// Directed plus randomized bench for sim_axi_slave, checked against a queue-based transaction model.
module tb_sim_axi_slave;
    localparam int          DW         = 512;
    localparam int          AW         = 64;
    localparam int          IW         = 4;
    localparam int          RD_LATENCY = 4;
    localparam logic [63:0] ADDR_LIMIT = 64'h1_0000_0000;

    typedef struct { logic [63:0] addr; logic [IW-1:0] id; logic [7:0] len; } rreq_t;
    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bexp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] wr_bursts, rd_bursts;
    int          total = 0;
    int          bad = 0;
    int          exp_wr = 0;
    int          exp_rd = 0;
    rreq_t       exp_rq[$];
    bexp_t       exp_b[$];

    sim_axi_slave_if #(.DW(DW), .AW(AW), .IW(IW)) bus ();

    sim_axi_slave #(.DW(DW), .AW(AW), .IW(IW), .AR_DEPTH(16), .WQ_DEPTH(16),
                    .RD_LATENCY(RD_LATENCY), .ADDR_LIMIT(ADDR_LIMIT)) dut (
        .clk(clk), .resetn(resetn), .s_axi(bus), .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model_resp(input logic [63:0] a);
        return (a >= ADDR_LIMIT) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [DW-1:0] model_data(input logic [63:0] a);
        return {(DW/64){a}};
    endfunction

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return ADDR_LIMIT + 64'({$urandom_range(0, 15), 6'd0});
            1:       return 64'hFFFF_FFFF_FFFF_FF80;
            default: return {32'h0, $urandom} & ~64'h3F;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [63:0] a, input logic [IW-1:0] id, input logic [7:0] len);
        int n = 0;
        bus.S_AXI_AWADDR = a; bus.S_AXI_AWID = id; bus.S_AXI_AWLEN = len; bus.S_AXI_AWVALID = 1'b1;
        while (!bus.S_AXI_AWREADY && n < 2000) begin tick(); n++; end
        if (!bus.S_AXI_AWREADY) begin
            chk("aw_timeout", DW'(1'b1), DW'(1'b0));
        end else begin
            exp_b.push_back('{id: id, resp: model_resp(a)});
            tick();
        end
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) begin
            int n = 0;
            bus.S_AXI_WDATA = {16{$urandom}}; bus.S_AXI_WLAST = (b == int'(len)); bus.S_AXI_WVALID = 1'b1;
            while (!bus.S_AXI_WREADY && n < 2000) begin tick(); n++; end
            if (!bus.S_AXI_WREADY) begin
                chk("w_timeout", DW'(1'b1), DW'(1'b0));
                break;
            end
            tick();
        end
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    endtask

    task automatic send_ar(input logic [63:0] a, input logic [IW-1:0] id, input logic [7:0] len);
        int n = 0;
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARID = id; bus.S_AXI_ARLEN = len; bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && n < 2000) begin tick(); n++; end
        if (!bus.S_AXI_ARREADY) begin
            chk("ar_timeout", DW'(1'b1), DW'(1'b0));
        end else begin
            exp_rq.push_back('{addr: a, id: id, len: len});
            tick();
        end
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic recv_b(input bit rnd);
        bexp_t e; logic stalled = 1'b0; logic [IW-1:0] pid; logic [1:0] presp; logic rdy; bit done = 1'b0;
        int n = 0;
        while (exp_b.size() == 0 && n < 4000) begin tick(); n++; end
        if (exp_b.size() == 0) begin chk("b_no_request", DW'(1'b1), DW'(1'b0)); return; end
        e = exp_b.pop_front();
        for (int k = 0; k < 1000 && !done; k++) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.S_AXI_BREADY = rdy;
            if (stalled) begin
                chk("b_hold_valid", DW'(bus.S_AXI_BVALID), DW'(1'b1));
                chk("b_hold_id", DW'(bus.S_AXI_BID), DW'(pid));
                chk("b_hold_resp", DW'(bus.S_AXI_BRESP), DW'(presp));
            end
            if (bus.S_AXI_BVALID && rdy) begin
                chk("b_id", DW'(bus.S_AXI_BID), DW'(e.id));
                chk("b_resp", DW'(bus.S_AXI_BRESP), DW'(e.resp));
                done = 1'b1;
            end
            stalled = bus.S_AXI_BVALID && !rdy; pid = bus.S_AXI_BID; presp = bus.S_AXI_BRESP;
            tick();
        end
        if (done) exp_wr++;
        else      chk("b_timeout", DW'(1'b1), DW'(1'b0));
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic recv_r(input bit rnd);
        rreq_t q; logic stalled; logic [DW-1:0] pdata; logic [IW-1:0] pid; logic [1:0] presp;
        logic plast; logic rdy; bit done;
        int n = 0;
        while (exp_rq.size() == 0 && n < 4000) begin tick(); n++; end
        if (exp_rq.size() == 0) begin chk("r_no_request", DW'(1'b1), DW'(1'b0)); return; end
        q = exp_rq.pop_front();
        for (int b = 0; b <= int'(q.len); b++) begin
            stalled = 1'b0; done = 1'b0;
            for (int k = 0; k < 1000 && !done; k++) begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.S_AXI_RREADY = rdy;
                if (stalled) begin
                    chk("r_hold_valid", DW'(bus.S_AXI_RVALID), DW'(1'b1));
                    chk("r_hold_data", bus.S_AXI_RDATA, pdata);
                    chk("r_hold_id", DW'(bus.S_AXI_RID), DW'(pid));
                    chk("r_hold_resp", DW'(bus.S_AXI_RRESP), DW'(presp));
                    chk("r_hold_last", DW'(bus.S_AXI_RLAST), DW'(plast));
                end
                if (bus.S_AXI_RVALID && rdy) begin
                    chk("r_data", bus.S_AXI_RDATA, model_data(q.addr + 64'(b) * 64'(DW/8)));
                    chk("r_id", DW'(bus.S_AXI_RID), DW'(q.id));
                    chk("r_resp", DW'(bus.S_AXI_RRESP), DW'(model_resp(q.addr)));
                    chk("r_last", DW'(bus.S_AXI_RLAST), DW'(b == int'(q.len)));
                    done = 1'b1;
                end
                stalled = bus.S_AXI_RVALID && !rdy; pdata = bus.S_AXI_RDATA; pid = bus.S_AXI_RID;
                presp = bus.S_AXI_RRESP; plast = bus.S_AXI_RLAST;
                tick();
            end
            if (!done) begin
                chk("r_timeout", DW'(1'b1), DW'(1'b0));
                bus.S_AXI_RREADY = 1'b0;
                return;
            end
        end
        exp_rd++;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        int n; int acc;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_AWSIZE = 3'd6; bus.S_AXI_AWBURST = 2'd1; bus.S_AXI_AWLOCK = 1'b0;
        bus.S_AXI_AWCACHE = 4'd0; bus.S_AXI_AWQOS = 4'd0; bus.S_AXI_AWPROT = 3'd0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '1; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARLEN = 8'd0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_ARSIZE = 3'd6; bus.S_AXI_ARBURST = 2'd1; bus.S_AXI_ARLOCK = 1'b0;
        bus.S_AXI_ARCACHE = 4'd0; bus.S_AXI_ARQOS = 4'd0; bus.S_AXI_ARPROT = 3'd0;
        bus.S_AXI_RREADY = 1'b0;

        // Reset hold
        repeat (5) tick();
        chk("rst_awready", DW'(bus.S_AXI_AWREADY), DW'(1'b0));
        chk("rst_wready", DW'(bus.S_AXI_WREADY), DW'(1'b0));
        chk("rst_arready", DW'(bus.S_AXI_ARREADY), DW'(1'b0));
        chk("rst_bvalid", DW'(bus.S_AXI_BVALID), DW'(1'b0));
        chk("rst_rvalid", DW'(bus.S_AXI_RVALID), DW'(1'b0));
        chk("rst_rlast", DW'(bus.S_AXI_RLAST), DW'(1'b0));
        chk("rst_rdata", bus.S_AXI_RDATA, '0);
        chk("rst_bid", DW'(bus.S_AXI_BID), '0);
        chk("rst_wr_bursts", DW'(wr_bursts), '0);
        chk("rst_rd_bursts", DW'(rd_bursts), '0);
        resetn = 1'b1;
        tick();
        chk("post_rst_awready", DW'(bus.S_AXI_AWREADY), DW'(1'b1));
        chk("post_rst_arready", DW'(bus.S_AXI_ARREADY), DW'(1'b1));
        chk("post_rst_wready", DW'(bus.S_AXI_WREADY), DW'(1'b0));

        // Single write burst
        send_aw(64'h1000, 4'd3, 8'd3);
        send_w(8'd3);
        recv_b(1'b0);
        chk("single_wr_bursts", DW'(wr_bursts), DW'(exp_wr));

        // Read latency and address-derived data
        send_ar(64'h2000, 4'd5, 8'd1);
        n = 0;
        while (!bus.S_AXI_RVALID && n < 50) begin tick(); n++; end
`ifdef SIM_AXI_SLAVE_STALL_EN
        chk("rd_first_valid_min", DW'(n >= (2 + RD_LATENCY - 1)), DW'(1'b1));
`else
        chk("rd_first_valid", DW'(n), DW'(2 + RD_LATENCY - 1));
`endif
        recv_r(1'b0);
        chk("rd_bursts_single", DW'(rd_bursts), DW'(exp_rd));

        // Out-of-range write and read
        send_aw(ADDR_LIMIT, 4'd7, 8'd0);
        send_w(8'd0);
        recv_b(1'b0);
        send_ar(ADDR_LIMIT, 4'd9, 8'd2);
        recv_r(1'b0);

        // Read queue fills: 16 queued plus one held by the sequencer
        bus.S_AXI_RREADY = 1'b0;
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            bus.S_AXI_ARADDR = 64'h1_0000 + 64'(i) * 64'h100;
            bus.S_AXI_ARID = 4'(i); bus.S_AXI_ARLEN = 8'($urandom_range(0, 3));
            bus.S_AXI_ARVALID = 1'b1;
            if (!bus.S_AXI_ARREADY) break;
            exp_rq.push_back('{addr: bus.S_AXI_ARADDR, id: bus.S_AXI_ARID, len: bus.S_AXI_ARLEN});
            acc++;
            tick();
        end
        bus.S_AXI_ARVALID = 1'b0;
        chk("arq_accepted", DW'(acc), DW'(17));
        repeat (5) tick();
        chk("arq_full_arready", DW'(bus.S_AXI_ARREADY), DW'(1'b0));
        for (int i = 0; i < acc; i++) recv_r(1'b0);
        chk("arq_drain_rd_bursts", DW'(rd_bursts), DW'(exp_rd));

        // Reset in the middle of a read burst
        send_ar(64'h3000, 4'd1, 8'd3);
        n = 0;
        while (!bus.S_AXI_RVALID && n < 50) begin tick(); n++; end
        chk("mid_rst_pre_rvalid", DW'(bus.S_AXI_RVALID), DW'(1'b1));
        resetn = 1'b0;
        tick();
        chk("mid_rst_rvalid", DW'(bus.S_AXI_RVALID), DW'(1'b0));
        chk("mid_rst_rd_bursts", DW'(rd_bursts), '0);
        exp_rq.delete(); exp_b.delete(); exp_wr = 0; exp_rd = 0;
        tick();
        resetn = 1'b1;
        bus.S_AXI_RREADY = 1'b1;
        n = 0;
        repeat (20) begin tick(); if (bus.S_AXI_RVALID) n++; end
        chk("mid_rst_no_resp", DW'(n), '0);
        bus.S_AXI_RREADY = 1'b0;

        // Randomized traffic with response backpressure
        fork
            for (int i = 0; i < 100; i++) begin
                logic [7:0] l;
                l = 8'($urandom_range(0, 3));
                send_aw(rand_addr(), 4'($urandom), l);
                send_w(l);
            end
            for (int i = 0; i < 100; i++) send_ar(rand_addr(), 4'($urandom), 8'($urandom_range(0, 3)));
            for (int i = 0; i < 100; i++) recv_b(1'b1);
            for (int i = 0; i < 100; i++) recv_r(1'b1);
        join
        tick();
        chk("rand_wr_bursts", DW'(wr_bursts), DW'(exp_wr));
        chk("rand_rd_bursts", DW'(rd_bursts), DW'(exp_rd));
        chk("rand_idle_bvalid", DW'(bus.S_AXI_BVALID), DW'(1'b0));
        chk("rand_idle_rvalid", DW'(bus.S_AXI_RVALID), DW'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
